// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid buffer, sync flush, registered reset out; PIPE_STAGE_PERF_EN adds stall/bubble counters
module pipe_stage_skid #(
  parameter int PAYLOAD_W = 106,
  parameter int ADDR_W = 5,
  parameter int OPC_W = 7,
  parameter logic [OPC_W-1:0] NOP_OPC = 7'b0010011
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 resetIn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_wen,
  input  logic [ADDR_W-1:0]    in_wbAddr,
  input  logic [OPC_W-1:0]     in_opcode,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_wen,
  output logic [ADDR_W-1:0]    out_wbAddr,
  output logic [OPC_W-1:0]     out_opcode,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 resetOut
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]     stallCnt,
  output logic [CNT_W-1:0]     bubbleCnt
`endif
);
  localparam int W = 1 + ADDR_W + OPC_W + PAYLOAD_W;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_main, r_skid, w_in;
  logic r_in_ready, r_reset_out, w_in_fire, w_out_fire, w_main_wen;
  logic [ADDR_W-1:0] w_main_addr;
  logic [OPC_W-1:0] w_main_opc;
  assign w_in = {in_wen, in_wbAddr, in_opcode, in_payload};
  assign {w_main_wen, w_main_addr, w_main_opc, out_payload} = r_main;
  assign out_valid = r_state != EMPTY;
  assign in_ready = r_in_ready;
  assign resetOut = r_reset_out;
  assign w_in_fire = in_valid & r_in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign out_wen = w_main_wen & out_valid;
  assign out_wbAddr = out_valid ? w_main_addr : '0;
  assign out_opcode = out_valid ? w_main_opc : NOP_OPC;
  always_comb begin
    w_next = r_state;
    w_next = flush ? EMPTY :
             r_state == EMPTY ? (w_in_fire ? BUSY : EMPTY) :
             r_state == BUSY ? ((w_in_fire && !w_out_fire) ? FULL : (!w_in_fire && w_out_fire) ? EMPTY : BUSY) :
             (w_out_fire ? BUSY : FULL);
  end
  always_ff @(posedge clk) begin
    if (!resetIn) begin
      r_state <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_in_ready <= w_next != FULL;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetIn) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      if (w_in_fire && (r_state == EMPTY || w_out_fire)) r_main <= w_in;
      else if (r_state == FULL && w_out_fire) r_main <= r_skid;
      if (w_in_fire && r_state == BUSY && !w_out_fire) r_skid <= w_in;
    end
  end
  always_ff @(posedge clk) r_reset_out <= resetIn;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall, r_bubble;
  assign stallCnt = r_stall;
  assign bubbleCnt = r_bubble;
  always_ff @(posedge clk) begin
    if (!resetIn) begin
      r_stall <= '0;
      r_bubble <= '0;
    end else begin
      if (out_valid && !out_ready && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
      if (!out_valid && out_ready && r_bubble != '1) r_bubble <= r_bubble + CNT_W'(1);
    end
  end
`else
`endif
endmodule
